// File: rtl/g15_bit_timing.sv
// g15_bit_timing: drum-timing generator that divides clk into bit times and counts bits and words.
//
// Optional build macro TIMING_STEP_EN adds the step_req input for single-step advance while run=0.
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   run       in   1 = timing advances, 0 = frozen
//   step_req  in   (TIMING_STEP_EN only) rising edge steps one bit time while run=0
//   bit_num   out  current bit time 0..BITS_PER_WORD-1
//   word_num  out  current word time 0..WORDS_PER_REV-1
//   bit_tick  out  one-cycle pulse on the first clk of each new bit time
//   mid_tick  out  one-cycle pulse at mid-bit
//   t0        out  bit_tick while bit_num==0
//   t28       out  bit_tick while bit_num==BITS_PER_WORD-1
//   rev_start out  t0 while word_num==0
//   word_even out  level, ~word_num[0]
module g15_bit_timing #(
    parameter int CLK_DIV       = 10,
    parameter int BITS_PER_WORD = 29,
    parameter int WORDS_PER_REV = 108
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
`ifdef TIMING_STEP_EN
    input  logic       step_req,
`endif
    output logic [4:0] bit_num,
    output logic [6:0] word_num,
    output logic       bit_tick,
    output logic       mid_tick,
    output logic       t0,
    output logic       t28,
    output logic       rev_start,
    output logic       word_even
);
    localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_MID = DW'(CLK_DIV / 2 - 1);
    localparam logic [4:0] BIT_LAST = 5'(BITS_PER_WORD - 1);
    localparam logic [6:0] WORD_LAST = 7'(WORDS_PER_REV - 1);

    generate
        if (CLK_DIV < 2) begin : g_bad_div
            $error("g15_bit_timing: CLK_DIV must be >= 2");
        end
    endgenerate

    logic [DW-1:0] div_cnt;
    logic          div_wrap;
    logic          adv;
    logic          step_fire;
    logic [4:0]    bit_nxt;
    logic [6:0]    word_nxt;

`ifdef TIMING_STEP_EN
    logic step_q;
    // Tracks step_req even during reset so a level held through reset is not seen as an edge.
    always_ff @(posedge clk) step_q <= step_req;
    assign step_fire = ~rst & ~run & step_req & ~step_q;
`else
    assign step_fire = 1'b0;
`endif

    always_comb begin
        div_wrap = div_cnt == DIV_LAST;
        adv      = (run & div_wrap) | step_fire;
        bit_nxt  = (bit_num == BIT_LAST) ? 5'd0 : bit_num + 5'd1;
        word_nxt = (bit_num != BIT_LAST) ? word_num : (word_num == WORD_LAST) ? 7'd0 : word_num + 7'd1;
    end

    // Reset parks the counters on the last bit of the last word so the first advance lands on bit 0 / word 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt   <= '0;
            bit_num   <= BIT_LAST;
            word_num  <= WORD_LAST;
            bit_tick  <= 1'b0;
            mid_tick  <= 1'b0;
            t0        <= 1'b0;
            t28       <= 1'b0;
            rev_start <= 1'b0;
        end else begin
            if (run)
                div_cnt <= div_wrap ? '0 : div_cnt + DW'(1);
            else if (step_fire)
                div_cnt <= '0;
            if (adv) begin
                bit_num  <= bit_nxt;
                word_num <= word_nxt;
            end
            // Strobes decode the incoming counter values so they coincide with bit_tick.
            bit_tick  <= adv;
            t0        <= adv & (bit_nxt == 5'd0);
            t28       <= adv & (bit_nxt == BIT_LAST);
            rev_start <= adv & (bit_nxt == 5'd0) & (word_nxt == 7'd0);
            mid_tick  <= run & (div_cnt == DIV_MID);
        end
    end

    assign word_even = ~word_num[0];
endmodule

// File: doc/g15_bit_timing.md
Name: g15_bit_timing

Overview:
- Drum-timing generator for the G-15 core: divides the FPGA clock into bit times, counts 29 bits per word and 108 words per drum revolution.
- Emits one-cycle registered strobes (bit start, mid-bit, T0, T28, revolution start).
- Sits directly upstream of the control sr_ff flip-flops; its strobes drive their s/r inputs.

Parameters:
- CLK_DIV, 10: clk cycles per bit time; must be ≥2, elaboration $error otherwise.
- BITS_PER_WORD, 29: bit times per word; bit_num range 0..28.
- WORDS_PER_REV, 108: word times per drum revolution; word_num range 0..107.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, synchronous, active-high.
- run  input  1  level; 1 = timing advances, 0 = frozen.
- bit_num  output  5  current bit time, registered.
- word_num  output  7  current word time, registered.
- bit_tick  output  1  one-cycle pulse, first clk of each new bit time.
- mid_tick  output  1  one-cycle pulse at mid-bit.
- t0  output  1  bit_tick while bit_num==0.
- t28  output  1  bit_tick while bit_num==BITS_PER_WORD-1.
- rev_start  output  1  t0 while word_num==0.
- word_even  output  1  level, ~word_num[0].

Behaviour:
Reset:
- div_cnt=0, bit_num=BITS_PER_WORD-1 (28), word_num=WORDS_PER_REV-1 (107).
- All pulse outputs 0; word_even=0.
- This positions the first advance onto bit 0 / word 0.

Prescaler:
- While run=1, div_cnt increments and wraps CLK_DIV-1 → 0.
- While run=0, div_cnt holds.

Bit advance:
- Occurs on the edge where run=1 and div_cnt==CLK_DIV-1.
- On that edge:
  - bit_num increments, wrapping BITS_PER_WORD-1 → 0.
  - On that wrap, word_num increments, wrapping WORDS_PER_REV-1 → 0.
  - bit_tick is registered to 1.
- In the cycle bit_tick=1, bit_num/word_num already hold the new values.

Strobes:
- t0, t28 and rev_start are registered on the same edge as bit_tick, so all four are cycle-coincident.
- Each strobe decodes the new counter values.

mid_tick:
- Registered 1 on the edge where run=1 and div_cnt==(CLK_DIV/2)-1 (integer division).
- Lands CLK_DIV/2 cycles after bit_tick.

Latency:
- First bit_tick occurs exactly CLK_DIV clk edges after the first cycle with run=1 following reset.
- bit_tick period is exactly CLK_DIV cycles while run stays 1.

run deasserted mid-bit:
- Counters and div_cnt freeze; no pulses.
- Pulses already registered complete normally (one cycle).
- On resume, the phase continues; no bit is skipped or repeated.

rst mid-operation:
- Overrides run.
- All state returns to reset values on the next edge.
- Any pulse asserted in that cycle drops.

Other rules:
- Pulses are never wider than one clk cycle.
- bit_tick and mid_tick never coincide (CLK_DIV≥2).
- Counter arithmetic is unsigned and wraps only at the stated limits; out-of-range values are unreachable.

Optional Feature:
Macro TIMING_STEP_EN.

Defined:
- Adds input port step_req (1 bit), registered internally for rising-edge detection.
- When run=0, a step_req rising edge performs one bit advance on the next edge: counters step, bit_tick and strobes fire as normal, div_cnt clears to 0, mid_tick is not generated.
- step_req is ignored while run=1 or rst=1.

Undefined:
- No step_req port.
- Timing advances only under run.

Test Plan:
- CLK_DIV=4, release rst, run=1 → bit_tick at 4th edge with bit_num=0, word_num=0, t0=1, rev_start=1, word_even=1; mid_tick 2 cycles later.
- Run 29 bit times → 29th tick shows bit_num=28, t28=1, word_num=0; next tick bit_num=0, word_num=1, t0=1, rev_start=0, word_even=0.
- Run 3132 (108×29) bit times → rev_start recurs exactly every 3132 ticks / 12528 clk cycles; word_num wraps 107→0.
- Drop run for 10 cycles when div_cnt=2 → no pulses during freeze; next bit_tick 2 cycles after run returns; bit_num sequence contiguous.
- Assert rst one cycle mid-word (e.g. bit 15, word 40) → next cycle bit_num=28, word_num=107, all pulses 0; restart matches the first scenario.
- TIMING_STEP_EN, run=0, three step_req pulses → exactly three bit_tick pulses, bit_num 0,1,2, no mid_tick; step_req with run=1 has no effect.
